// File: rtl/gp_weight_pkg.sv
// gp_weight_pkg: loader FSM states and default bank geometry shared by the weight loader files.
package gp_weight_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam int WIDTH_DEF = 16;
    localparam int ADDR_DEF = 7;
    localparam int NUM_DEF = 16;
endpackage

// File: rtl/weight_bank_ram.sv
// weight_bank_ram: one-write-port, async-read distributed RAM; same-cycle read returns pre-write data.
module weight_bank_ram #(
    parameter int WIDTH = 16,
    parameter int ADDR = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDR-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ADDR-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [0:(1<<ADDR)-1];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/weight_bank_loader.sv
// weight_bank_loader: streams NUM*2**ADDR words round-robin into NUM async-read weight banks.
// Define WEIGHT_LOADER_CHECKSUM_EN to add exp_sum/sum_ok with a running modulo-2**WIDTH checksum.
module weight_bank_loader
    import gp_weight_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ADDR = ADDR_DEF,
    parameter int NUM = NUM_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ADDR-1:0]  address,
    output logic [WIDTH-1:0] rom_out [0:NUM-1],
    output logic             busy,
    output logic             done
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    input  logic [WIDTH-1:0] exp_sum,
    output logic             sum_ok
`endif
);
    localparam int BW = NUM > 1 ? $clog2(NUM) : 1;

    state_t          state;
    logic [BW-1:0]   b;
    logic [ADDR-1:0] a;
    logic            xfer;
    logic            last_b;

    // reset must also block the bank write that in_ready would otherwise allow
    assign xfer = in_valid && in_ready && !rst;
    assign last_b = b == BW'(NUM - 1);

    genvar i;
    for (i = 0; i < NUM; i++) begin : g_bank
        weight_bank_ram #(.WIDTH(WIDTH), .ADDR(ADDR)) u_bank (
            .clk  (clk),
            .we   (xfer && b == BW'(i)),
            .waddr(a),
            .wdata(in_data),
            .raddr(address),
            .rdata(rom_out[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            b <= '0;
            a <= '0;
            in_ready <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start && state != LOAD) begin
            state <= LOAD;
            b <= '0;
            a <= '0;
            in_ready <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (xfer) begin
            b <= last_b ? '0 : b + BW'(1);
            a <= last_b ? a + ADDR'(1) : a;
            if (last_b && &a) begin
                state <= DONE;
                in_ready <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum;

    always_ff @(posedge clk)
        if (rst || (start && state != LOAD)) sum <= '0;
        else if (xfer) sum <= sum + in_data;

    assign sum_ok = done && sum == exp_sum;
`endif
endmodule
